// File: rtl/mcpu_gen_pkg.sv
// Shared opcodes and FSM state encoding for the mcpu_gen accumulator core.
// MCPU_GEN_HALT_EN adds the HALT state used for self-jump halt detection.
package mcpu_gen_pkg;

    localparam logic [1:0] OP_NOR = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_STA = 2'b10;
    localparam logic [1:0] OP_JCC = 2'b11;

    typedef enum logic [2:0] {
        FETCH,
        EX_NOR,
        EX_ADD,
        EX_STA,
        JCC_NT
`ifdef MCPU_GEN_HALT_EN
        , HALT
`endif
    } state_t;

endpackage

// File: rtl/mcpu_gen_if.sv
// Single-port memory bus: registered address, separate read/write data, re/we strobes
// held until the memory answers with mem_rdy.
interface mcpu_gen_if #(
    parameter int DW = 8,
    parameter int AW = 6
) ();

    logic [AW-1:0] addr;
    logic [DW-1:0] data_i;
    logic [DW-1:0] data_o;
    logic          mem_re;
    logic          mem_we;
    logic          mem_rdy;

    modport master (
        output addr, data_o, mem_re, mem_we,
        input  data_i, mem_rdy
    );

    modport slave (
        input  addr, data_o, mem_re, mem_we,
        output data_i, mem_rdy
    );

endinterface

// File: rtl/mcpu_gen_alu.sv
// Combinational NOR/ADD datapath; other opcodes pass the accumulator through.
// Zero latency, no flow control.
module mcpu_gen_alu
    import mcpu_gen_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [1:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] res,
    output logic          cout
);

    logic [DW:0] sum;

    assign sum = {1'b0, a} + {1'b0, b};

    always_comb begin
        res  = a;
        cout = 1'b0;
        case (op)
            OP_NOR: res = ~(a | b);
            OP_ADD: {cout, res} = sum;
            default: ;
        endcase
    end

endmodule

// File: rtl/mcpu_gen.sv
// Accumulator CPU (NOR/ADD/STA/JCC): 2 cycles per instruction, 1 for a taken JCC,
// +1 per mem_rdy=0 cycle. MCPU_GEN_HALT_EN enables halt on a taken self-jump.
module mcpu_gen
    import mcpu_gen_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    mcpu_gen_if.master    bus,
    output logic [DW-1:0] acc,
    output logic          carry,
    output logic          halted
);

    if (DW < AW + 2) begin : g_bad_width
        $error("mcpu_gen: DW must be at least AW+2");
    end

    state_t        state, state_nxt;
    logic [AW-1:0] pc, pc_nxt;
    logic [AW-1:0] adreg, adreg_nxt;
    logic [DW-1:0] acc_nxt;
    logic          carry_nxt;

    logic [1:0]    opc;
    logic [AW-1:0] tgt;
    logic [DW-1:0] alu_res;
    logic          alu_cout;

    assign opc = bus.data_i[DW-1 -: 2];
    assign tgt = bus.data_i[AW-1:0];

    // Bits between opcode and target are don't-care.
    if (DW > AW + 2) begin : g_mid
        logic unused_mid;
        assign unused_mid = ^bus.data_i[DW-3:AW];
    end

    mcpu_gen_alu #(.DW(DW)) u_alu (
        .op   ((state == EX_ADD) ? OP_ADD : OP_NOR),
        .a    (acc),
        .b    (bus.data_i),
        .res  (alu_res),
        .cout (alu_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
            pc    <= '0;
            adreg <= '0;
            acc   <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            adreg <= adreg_nxt;
            acc   <= acc_nxt;
            carry <= carry_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        adreg_nxt = adreg;
        acc_nxt   = acc;
        carry_nxt = carry;
        case (state)
            FETCH: begin
                if (bus.mem_rdy) begin
                    pc_nxt    = adreg + AW'(1);
                    adreg_nxt = tgt;
                    case (opc)
                        OP_NOR: state_nxt = EX_NOR;
                        OP_ADD: state_nxt = EX_ADD;
                        OP_STA: state_nxt = EX_STA;
                        default: begin
                            if (carry) begin
                                state_nxt = JCC_NT;
                            end else begin
`ifdef MCPU_GEN_HALT_EN
                                state_nxt = (tgt == adreg) ? HALT : FETCH;
`else
                                state_nxt = FETCH;
`endif
                            end
                        end
                    endcase
                end
            end
            EX_NOR, EX_ADD: begin
                if (bus.mem_rdy) begin
                    acc_nxt   = alu_res;
                    if (state == EX_ADD) carry_nxt = alu_cout;
                    adreg_nxt = pc;
                    state_nxt = FETCH;
                end
            end
            EX_STA: begin
                if (bus.mem_rdy) begin
                    adreg_nxt = pc;
                    state_nxt = FETCH;
                end
            end
            JCC_NT: begin
                carry_nxt = 1'b0;
                adreg_nxt = pc;
                state_nxt = FETCH;
            end
`ifdef MCPU_GEN_HALT_EN
            HALT: ;
`endif
            default: state_nxt = FETCH;
        endcase
    end

    // Strobes depend only on state and rst so an in-flight store dies with reset.
    assign bus.mem_re = rst && (state == FETCH || state == EX_NOR || state == EX_ADD);
    assign bus.mem_we = rst && (state == EX_STA);
    assign bus.addr   = adreg;
    assign bus.data_o = (state == EX_STA) ? acc : '0;

`ifdef MCPU_GEN_HALT_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_mcpu_gen.sv
// Directed bench for mcpu_gen (DW=8, AW=6) against a zero-wait memory with stall control.
module tb_mcpu_gen;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk;
    logic          rst;
    logic          rdy;
    logic [DW-1:0] acc;
    logic          carry;
    logic          halted;
    logic [DW-1:0] mem [64];
    int            n_chk;
    int            n_fail;
    int            wr_cnt = 0;
    int            w0;

    mcpu_gen_if #(.DW(DW), .AW(AW)) bus ();

    mcpu_gen #(.DW(DW), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .acc    (acc),
        .carry  (carry),
        .halted (halted)
    );

    assign bus.data_i  = mem[bus.addr];
    assign bus.mem_rdy = rdy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_we && bus.mem_rdy) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        rdy    = 1'b1;
        clear_mem();

        // NOR then ADD with carry-out
        mem[0] = 8'h3F; mem[1] = 8'h7E; mem[8'h3E] = 8'h01;
        do_reset();
        check("rst_re",    32'(bus.mem_re), 1);
        check("rst_addr",  32'(bus.addr), 0);
        check("rst_acc",   32'(acc), 0);
        check("rst_carry", 32'(carry), 0);
        check("rst_halt",  32'(halted), 0);
        cyc();
        check("nor_addr", 32'(bus.addr), 'h3F);
        check("nor_re",   32'(bus.mem_re), 1);
        cyc();
        check("nor_acc",  32'(acc), 'hFF);
        check("f2_addr",  32'(bus.addr), 1);
        cyc();
        check("add_addr", 32'(bus.addr), 'h3E);
        cyc();
        check("add_acc",   32'(acc), 0);
        check("add_carry", 32'(carry), 1);
        check("f3_addr",   32'(bus.addr), 2);

        // Three-cycle stall in EX_ADD
        do_reset();
        repeat (3) cyc();
        rdy = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("stall_acc",  32'(acc), 'hFF);
            check("stall_addr", 32'(bus.addr), 'h3E);
            check("stall_re",   32'(bus.mem_re), 1);
            cyc();
        end
        check("stall_hold", 32'(acc), 'hFF);
        rdy = 1'b1;
        cyc();
        check("stall_acc_upd", 32'(acc), 0);
        check("stall_carry",   32'(carry), 1);

        // Store
        clear_mem();
        mem[0] = 8'h3F; mem[1] = 8'hBD;
        do_reset();
        w0 = wr_cnt;
        cyc();
        cyc();
        check("sta_we_pre", 32'(bus.mem_we), 0);
        cyc();
        check("sta_we",   32'(bus.mem_we), 1);
        check("sta_addr", 32'(bus.addr), 'h3D);
        check("sta_data", 32'(bus.data_o), 'hFF);
        cyc();
        check("sta_we_post",   32'(bus.mem_we), 0);
        check("sta_data_post", 32'(bus.data_o), 0);
        check("sta_next_addr", 32'(bus.addr), 2);
        check("sta_wr_count",  32'(wr_cnt - w0), 1);

        // Reset held for three cycles across a pending store
        do_reset();
        repeat (3) cyc();
        w0  = wr_cnt;
        rst = 1'b0;
        #1;
        check("rsta_we0", 32'(bus.mem_we), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rsta_we",   32'(bus.mem_we), 0);
            check("rsta_re",   32'(bus.mem_re), 0);
            check("rsta_acc",  32'(acc), 0);
            check("rsta_addr", 32'(bus.addr), 0);
        end
        rst = 1'b1;
        #1;
        check("rsta_rel_re",   32'(bus.mem_re), 1);
        check("rsta_rel_addr", 32'(bus.addr), 0);
        check("rsta_no_write", 32'(wr_cnt - w0), 0);

        // Branches and pc wrap
        clear_mem();
        mem[0] = 8'h3F; mem[1] = 8'h7E; mem[8'h3E] = 8'h01;
        mem[2] = 8'hD0; mem[3] = 8'hD0; mem[8'h10] = 8'hFF;
        do_reset();
        repeat (4) cyc();
        check("jnt_carry_in", 32'(carry), 1);
        check("jnt_addr",     32'(bus.addr), 2);
        cyc();
        check("jnt_re", 32'(bus.mem_re), 0);
        check("jnt_we", 32'(bus.mem_we), 0);
        cyc();
        check("jnt_carry", 32'(carry), 0);
        check("jnt_next",  32'(bus.addr), 3);
        cyc();
        check("jt_target", 32'(bus.addr), 'h10);
        cyc();
        check("jt2_target", 32'(bus.addr), 'h3F);
        cyc();
        check("wrap_ex_addr", 32'(bus.addr), 0);
        cyc();
        check("wrap_fetch", 32'(bus.addr), 0);
        check("wrap_acc",   32'(acc), 'hC0);

        // Self-jump
        clear_mem();
        mem[0] = 8'hC5; mem[5] = 8'hC5;
        do_reset();
        check("halt_f0", 32'(bus.addr), 0);
        cyc();
        check("halt_f5", 32'(bus.addr), 5);
        check("halt_pre", 32'(halted), 0);
        for (int i = 0; i < 2; i++) begin
            cyc();
`ifdef MCPU_GEN_HALT_EN
            check("halt_flag", 32'(halted), 1);
            check("halt_re",   32'(bus.mem_re), 0);
            check("halt_we",   32'(bus.mem_we), 0);
`else
            check("self_addr", 32'(bus.addr), 5);
            check("self_re",   32'(bus.mem_re), 1);
            check("self_halt", 32'(halted), 0);
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
